// File: rtl/ddp_hdr_framer.sv
// DDP header framer: queues RDMAP headers in a small FIFO and emits each as a
// two-beat DDP frame (HEAD then TAIL) under a valid/ready handshake.
module ddp_hdr_framer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] rdmap2DdpHeader,
    input  logic [7:0]  rdmap2DdpCtrl,
    input  logic        rdmap2DdpHdrValid,
    output logic [31:0] ddpData,
    output logic        ddpValid,
    output logic        ddpSop,
    output logic        ddpEop,
    input  logic        ddpReady,
    input  logic        clearOvf,
    output logic        hdrOverflow,
    output logic [7:0]  dropCount,
    output logic [7:0]  msn
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, HEAD, TAIL} state_t;

    state_t        state, stateNext;
    logic [55:0]   fifoMem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic [55:0]   headEntry;
    logic          full, pop, push, drop;

    assign headEntry = fifoMem[rdPtr];
    assign full      = (count == FULL_CNT);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign push      = rdmap2DdpHdrValid && (!full || pop);
    assign drop      = rdmap2DdpHdrValid && full && !pop;

    always_comb begin
        stateNext = state;
        ddpValid  = 1'b0;
        ddpSop    = 1'b0;
        ddpEop    = 1'b0;
        ddpData   = '0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) stateNext = HEAD;
            end
            HEAD: begin
                ddpValid = 1'b1;
                ddpSop   = 1'b1;
                ddpData  = {headEntry[55:48], msn, headEntry[47:32]};
                if (ddpReady) stateNext = TAIL;
            end
            TAIL: begin
                ddpValid = 1'b1;
                ddpEop   = 1'b1;
                ddpData  = headEntry[31:0];
                if (ddpReady) begin
                    pop       = 1'b1;
                    stateNext = (count > CW'(1)) ? HEAD : IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr] <= {rdmap2DdpCtrl, rdmap2DdpHeader};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            msn         <= '0;
            hdrOverflow <= 1'b0;
            dropCount   <= '0;
        end else begin
            state <= stateNext;
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
                msn   <= msn + 8'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop coinciding with clearOvf restarts the count at one.
            if (drop) begin
                hdrOverflow <= 1'b1;
                if (clearOvf)                dropCount <= 8'd1;
                else if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
            end else if (clearOvf) begin
                hdrOverflow <= 1'b0;
                dropCount   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ddp_hdr_framer.sv
// Directed self-checking bench for ddp_hdr_framer (DEPTH=4).
module tb_ddp_hdr_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic [47:0] rdmap2DdpHeader;
    logic [7:0]  rdmap2DdpCtrl;
    logic        rdmap2DdpHdrValid;
    logic [31:0] ddpData;
    logic        ddpValid, ddpSop, ddpEop;
    logic        ddpReady;
    logic        clearOvf;
    logic        hdrOverflow;
    logic [7:0]  dropCount;
    logic [7:0]  msn;

    int cmpCnt = 0;
    int errCnt = 0;

    ddp_hdr_framer #(.DEPTH(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .rdmap2DdpHeader   (rdmap2DdpHeader),
        .rdmap2DdpCtrl     (rdmap2DdpCtrl),
        .rdmap2DdpHdrValid (rdmap2DdpHdrValid),
        .ddpData           (ddpData),
        .ddpValid          (ddpValid),
        .ddpSop            (ddpSop),
        .ddpEop            (ddpEop),
        .ddpReady          (ddpReady),
        .clearOvf          (clearOvf),
        .hdrOverflow       (hdrOverflow),
        .dropCount         (dropCount),
        .msn               (msn)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmpCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setHdr(input int idx);
        rdmap2DdpHeader = {16'(16'hA000 + idx), 32'hB000_0000 + 32'(idx)};
        rdmap2DdpCtrl   = 8'(8'h10 + idx);
    endtask

    function automatic logic [31:0] expBeat(input int idx, input int m, input bit tail);
        if (tail) return 32'hB000_0000 + 32'(idx);
        return {8'(8'h10 + idx), 8'(m), 16'(16'hA000 + idx)};
    endfunction

    task automatic resetDut();
        reset = 1'b0;
        rdmap2DdpHdrValid = 1'b0;
        rdmap2DdpHeader = '0;
        rdmap2DdpCtrl = '0;
        ddpReady = 1'b0;
        clearOvf = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Push headers firstIdx..firstIdx+n-1 on consecutive cycles.
    task automatic pushRun(input int firstIdx, input int n);
        for (int i = 0; i < n; i++) begin
            setHdr(firstIdx + i);
            rdmap2DdpHdrValid = 1'b1;
            step();
        end
        rdmap2DdpHdrValid = 1'b0;
    endtask

    task automatic drainCheck(input int firstIdx, input int firstMsn, input int nFrames);
        ddpReady = 1'b1;
        for (int b = 0; b < 2 * nFrames; b++) begin
            checkVal("drainValid", 32'(ddpValid), 32'd1);
            checkVal("drainSop", 32'(ddpSop), 32'((b % 2) == 0));
            checkVal("drainEop", 32'(ddpEop), 32'((b % 2) == 1));
            checkVal("drainData", ddpData, expBeat(firstIdx + b / 2, firstMsn + b / 2, bit'(b % 2)));
            step();
        end
        checkVal("drainIdle", 32'(ddpValid), 32'd0);
        checkVal("drainIdleData", ddpData, 32'd0);
    endtask

    initial begin
        // Reset state
        resetDut();
        checkVal("rstValid", 32'(ddpValid), 32'd0);
        checkVal("rstSop", 32'(ddpSop), 32'd0);
        checkVal("rstEop", 32'(ddpEop), 32'd0);
        checkVal("rstData", ddpData, 32'd0);
        checkVal("rstMsn", 32'(msn), 32'd0);
        checkVal("rstOvf", 32'(hdrOverflow), 32'd0);
        checkVal("rstDrop", 32'(dropCount), 32'd0);

        // Single header, two-cycle latency
        ddpReady = 1'b1;
        rdmap2DdpHeader = 48'h1234_5678_9ABC;
        rdmap2DdpCtrl = 8'h03;
        rdmap2DdpHdrValid = 1'b1;
        step();
        rdmap2DdpHdrValid = 1'b0;
        checkVal("singleN1Valid", 32'(ddpValid), 32'd0);
        step();
        checkVal("singleHeadValid", 32'(ddpValid), 32'd1);
        checkVal("singleHeadSop", 32'(ddpSop), 32'd1);
        checkVal("singleHeadEop", 32'(ddpEop), 32'd0);
        checkVal("singleHeadData", ddpData, 32'h0300_1234);
        step();
        checkVal("singleTailEop", 32'(ddpEop), 32'd1);
        checkVal("singleTailSop", 32'(ddpSop), 32'd0);
        checkVal("singleTailData", ddpData, 32'h5678_9ABC);
        step();
        checkVal("singleDoneValid", 32'(ddpValid), 32'd0);
        checkVal("singleMsn", 32'(msn), 32'd1);

        // Five strobes while stalled: fifth dropped, then four frames back-to-back
        resetDut();
        pushRun(1, 5);
        checkVal("ovfFlag", 32'(hdrOverflow), 32'd1);
        checkVal("ovfCount", 32'(dropCount), 32'd1);
        checkVal("ovfHeadStalled", ddpData, expBeat(1, 0, 1'b0));
        drainCheck(1, 0, 4);
        checkVal("ovfMsn", 32'(msn), 32'd4);

        // Push into full FIFO coincident with TAIL handshake
        resetDut();
        pushRun(1, 4);
        ddpReady = 1'b1;
        step();
        checkVal("coinTail", 32'(ddpEop), 32'd1);
        setHdr(5);
        rdmap2DdpHdrValid = 1'b1;
        step();
        rdmap2DdpHdrValid = 1'b0;
        ddpReady = 1'b0;
        checkVal("coinNoOvf", 32'(hdrOverflow), 32'd0);
        checkVal("coinNoDrop", 32'(dropCount), 32'd0);
        setHdr(6);
        rdmap2DdpHdrValid = 1'b1;
        step();
        checkVal("coinStillFullOvf", 32'(hdrOverflow), 32'd1);
        checkVal("coinStillFullDrop", 32'(dropCount), 32'd1);
        setHdr(7);
        clearOvf = 1'b1;
        step();
        rdmap2DdpHdrValid = 1'b0;
        checkVal("clrDropWinsOvf", 32'(hdrOverflow), 32'd1);
        checkVal("clrDropWinsCnt", 32'(dropCount), 32'd1);
        step();
        clearOvf = 1'b0;
        checkVal("clrOvf", 32'(hdrOverflow), 32'd0);
        checkVal("clrCnt", 32'(dropCount), 32'd0);
        drainCheck(2, 1, 4);

        // ddpReady toggling every cycle across three frames
        resetDut();
        pushRun(1, 3);
        begin
            int b;
            b = 0;
            for (int cyc = 0; cyc < 20 && b < 6; cyc++) begin
                ddpReady = ((cyc % 2) == 0);
                checkVal("togValid", 32'(ddpValid), 32'd1);
                checkVal("togSop", 32'(ddpSop), 32'((b % 2) == 0));
                checkVal("togEop", 32'(ddpEop), 32'((b % 2) == 1));
                checkVal("togData", ddpData, expBeat(1 + b / 2, b / 2, bit'(b % 2)));
                step();
                if ((cyc % 2) == 0) b++;
            end
            checkVal("togBeats", 32'(b), 32'd6);
        end
        checkVal("togIdle", 32'(ddpValid), 32'd0);
        checkVal("togMsn", 32'(msn), 32'd3);

        // msn wrap after 256 frames
        resetDut();
        ddpReady = 1'b1;
        for (int j = 0; j < 256; j++) begin
            setHdr(j);
            rdmap2DdpHdrValid = 1'b1;
            step();
            rdmap2DdpHdrValid = 1'b0;
            step();
            step();
            step();
            if (j == 127) checkVal("wrapMid", 32'(msn), 32'd128);
        end
        checkVal("wrapMsn", 32'(msn), 32'd0);
        setHdr(256);
        rdmap2DdpHdrValid = 1'b1;
        step();
        rdmap2DdpHdrValid = 1'b0;
        step();
        checkVal("wrapHeadSop", 32'(ddpSop), 32'd1);
        checkVal("wrapHeadData", ddpData, expBeat(256, 0, 1'b0));

        // Reset asserted mid-frame in TAIL with two entries queued behind
        resetDut();
        pushRun(1, 3);
        ddpReady = 1'b1;
        step();
        ddpReady = 1'b0;
        checkVal("midTailEop", 32'(ddpEop), 32'd1);
        reset = 1'b0;
        #1;
        checkVal("midRstValid", 32'(ddpValid), 32'd0);
        checkVal("midRstSop", 32'(ddpSop), 32'd0);
        checkVal("midRstEop", 32'(ddpEop), 32'd0);
        checkVal("midRstData", ddpData, 32'd0);
        step();
        reset = 1'b1;
        ddpReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checkVal("postRstValid", 32'(ddpValid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/ddp_hdr_framer.md
DDP_HDR_FRAMER -- requirements
Module: ddp_hdr_framer

Interface
REQ-001 Parameter DEPTH, default 4, header FIFO entries (power of two, >= 2).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rdmap2DdpHeader  input  48  RDMAP header from the RDMAP header stage.
REQ-005 rdmap2DdpCtrl  input  8  RDMAP control/opcode for the header.
REQ-006 rdmap2DdpHdrValid  input  1  one-cycle strobe, header+ctrl valid; no backpressure path upstream.
REQ-007 ddpData  output  32  framed DDP beat.
REQ-008 ddpValid  output  1  ddpData valid.
REQ-009 ddpSop  output  1  first beat of frame.
REQ-010 ddpEop  output  1  last beat of frame.
REQ-011 ddpReady  input  1  downstream accepts beat when ddpValid&ddpReady.
REQ-012 clearOvf  input  1  clears overflow flag and drop counter.
REQ-013 hdrOverflow  output  1  sticky, a header was dropped.
REQ-014 dropCount  output  8  headers dropped, saturating.
REQ-015 msn  output  8  current message sequence number.

Function
REQ-016 FIFO entry SHALL be {ctrl[7:0], header[47:0]}, written on the rising edge ending any cycle with rdmap2DdpHdrValid=1 and FIFO not full.
REQ-017 FIFO occupancy SHALL be a registered count 0..DEPTH; read/write pointers SHALL wrap modulo DEPTH.
REQ-018 Full = count==DEPTH; a strobe while full SHALL be dropped, except when a pop occurs in the same cycle, which SHALL accept the push (count unchanged).
REQ-019 A dropped strobe SHALL set hdrOverflow and increment dropCount, holding at 255.
REQ-020 clearOvf SHALL zero hdrOverflow and dropCount next edge; a drop in the same cycle SHALL win (flag=1, dropCount=1).
REQ-021 FSM states IDLE, HEAD, TAIL; encoding free.
REQ-022 IDLE->HEAD when count!=0; else stay.
REQ-023 HEAD->TAIL on ddpReady; else hold HEAD with data stable.
REQ-024 TAIL on ddpReady: pop FIFO; ->HEAD if count>1, else ->IDLE; without ddpReady hold TAIL.
REQ-025 ddpValid=1 in HEAD and TAIL only; ddpSop=1 only in HEAD; ddpEop=1 only in TAIL.
REQ-026 HEAD beat: ddpData = {ctrl, msn, header[47:32]} of FIFO head.
REQ-027 TAIL beat: ddpData = header[31:0] of FIFO head.
REQ-028 msn SHALL increment by 1 on each TAIL handshake, wrapping 255->0.
REQ-029 In IDLE ddpData SHALL be 0.
REQ-030 Latency: strobe in cycle N, FIFO empty, FSM IDLE -> HEAD beat valid in cycle N+2.
REQ-031 Back-to-back frames SHALL emit with no idle cycle when ddpReady stays 1 and FIFO non-empty.
REQ-032 Beats SHALL never be dropped or duplicated once ddpValid is asserted.

Reset
REQ-033 reset low SHALL immediately force FSM IDLE, count 0, pointers 0, msn 0, hdrOverflow 0, dropCount 0, ddpValid/ddpSop/ddpEop 0, ddpData 0.
REQ-034 Reset mid-frame SHALL discard the partial frame and all FIFO contents; no beat emitted after release until a new strobe.
REQ-035 FIFO storage need not be reset.

Verification
REQ-036 Single header 0x123456789ABC, ctrl 0x03, ddpReady=1 -> cycle N+2 beat 0x03001234 sop; N+3 beat 0x56789ABC eop; msn=1.
REQ-037 Five strobes back-to-back, ddpReady=0 (DEPTH=4) -> fifth dropped, hdrOverflow=1, dropCount=1; release ready -> 4 frames, 8 consecutive beats, msn 0..3 in HEAD beats.
REQ-038 ddpReady toggled 1/0 each cycle during 3 frames -> data stable while stalled, sop/eop alternate correctly, no loss.
REQ-039 256 frames -> msn in 257th HEAD beat = 0x00 (wrap).
REQ-040 FIFO full, strobe coincident with TAIL handshake -> accepted, no drop, count stays 4.
REQ-041 Assert reset while in TAIL with 2 entries queued -> all outputs 0 immediately; after release ddpValid stays 0 with no strobes.
